int2float_pipe: RTL and testbench

INT2FLOAT_PIPE -- requirements
Module: int2float_pipe

---
 rtl/int2float_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_int2float_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int2float_pipe.sv
// Two-stage integer to small-float converter (man * 2^exp, no hidden bit)
// with valid/ready handshaking, optional round-half-even and overflow counting.

module int2float_pipe_chk #(
  parameter int OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             out_valid,
  input  logic             out_ready,
  input  logic [OUT_W-1:0] out_data,
  input  logic             out_inexact,
  input  logic             out_ovf
);

  a_hold_when_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) &&
                                   $stable(out_inexact) && $stable(out_ovf)));

  a_ovf_implies_inexact: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && out_ovf) |-> out_inexact);

endmodule

module int2float_pipe #(
  parameter int IN_W   = 11,
  parameter int EXP_W  = 3,
  parameter int MAN_W  = 4,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          rnd_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIGNED+EXP_W+MAN_W-1:0] out_data,
  output logic                          out_inexact,
  output logic                          out_ovf,
  output logic [CNT_W-1:0]              ovf_cnt,
  input  logic                          cnt_clr
);

  localparam int OUT_W = SIGNED + EXP_W + MAN_W;
  localparam int IDX_W = 6;
  // Internal exponent is wide enough to hold the pre-saturation value.
  localparam int XE_W  = 8;

  localparam logic [IN_W-1:0]  ONE_IN    = {{(IN_W-1){1'b0}}, 1'b1};
  localparam logic [XE_W-1:0]  EXP_MAX   = XE_W'((2 ** EXP_W) - 1);
  localparam logic [XE_W-1:0]  MAN_SHIFT = XE_W'(MAN_W - 1);
  localparam logic [IDX_W-1:0] MAN_IDX   = IDX_W'(MAN_W);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              s1_valid_r;
  logic [IN_W-1:0]   s1_mag_r;
  logic              s1_sign_r;
  logic [IDX_W-1:0]  s1_lead_r;
  logic              s1_rnd_r;

  logic              s2_load_s;
  logic              s1_adv_s;
  logic              accept_s;
  logic              consume_s;

  logic [IN_W-1:0]   mag_s;
  logic              sign_s;
  logic [IDX_W-1:0]  lead_s;

  logic [XE_W-1:0]   exp_s;
  logic [IN_W-1:0]   shifted_s;
  logic [IN_W-1:0]   mask_s;
  logic [IN_W-1:0]   rem_s;
  logic [IN_W-1:0]   half_s;
  logic [MAN_W:0]    man0_s;
  logic [MAN_W:0]    man1_s;
  logic              inc_s;
  logic [XE_W-1:0]   exp_fin_s;
  logic [MAN_W-1:0]  man_fin_s;
  logic              inexact_s;
  logic              ovf_s;
  logic [OUT_W-1:0]  data_s;

  assign s2_load_s = !out_valid || out_ready;
  assign s1_adv_s  = s1_valid_r && s2_load_s;
  assign in_ready  = !s1_valid_r || s1_adv_s;
  assign accept_s  = in_valid && in_ready;
  assign consume_s = out_valid && out_ready;

  // Stage 1 combinational: magnitude and sign of the incoming word.
  always_comb begin
    sign_s = 1'b0;
    mag_s  = in_data;
    if ((SIGNED != 0) && in_data[IN_W-1]) begin
      sign_s = 1'b1;
      mag_s  = ~in_data + ONE_IN;
    end else begin
      sign_s = 1'b0;
      mag_s  = in_data;
    end
  end

  // Stage 1 combinational: index of the leading one (0 for a zero magnitude).
  always_comb begin
    lead_s = '0;
    for (int i = 0; i < IN_W; i++) begin
      lead_s = mag_s[i] ? IDX_W'(i) : lead_s;
    end
  end

  // Stage 1 register: captures each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_mag_r   <= '0;
      s1_sign_r  <= 1'b0;
      s1_lead_r  <= '0;
      s1_rnd_r   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_r <= in_valid;
      end
      if (accept_s) begin
        s1_mag_r  <= mag_s;
        s1_sign_r <= sign_s;
        s1_lead_r <= lead_s;
        s1_rnd_r  <= rnd_mode;
      end
    end
  end

  // Stage 2 combinational: shift, round, saturate and pack.
  always_comb begin
    if (s1_lead_r >= MAN_IDX) begin
      exp_s = XE_W'(s1_lead_r) - MAN_SHIFT;
    end else begin
      exp_s = '0;
    end
    shifted_s = s1_mag_r >> exp_s;
    mask_s    = ~({IN_W{1'b1}} << exp_s);
    rem_s     = s1_mag_r & mask_s;
    if (exp_s != '0) begin
      half_s = ONE_IN << (exp_s - 8'd1);
    end else begin
      half_s = '0;
    end
    man0_s = (MAN_W+1)'(shifted_s);
    inc_s  = s1_rnd_r && (exp_s != '0) &&
             ((rem_s > half_s) || ((rem_s == half_s) && shifted_s[0]));
    man1_s = man0_s + {{MAN_W{1'b0}}, inc_s};
    // A rounding carry renormalises to half-scale mantissa and bumps the exponent.
    if (man1_s[MAN_W]) begin
      man_fin_s = {1'b1, {(MAN_W-1){1'b0}}};
      exp_fin_s = exp_s + 8'd1;
    end else begin
      man_fin_s = man1_s[MAN_W-1:0];
      exp_fin_s = exp_s;
    end
    inexact_s = (rem_s != '0);
    ovf_s     = 1'b0;
    if (exp_fin_s > EXP_MAX) begin
      ovf_s     = 1'b1;
      inexact_s = 1'b1;
      exp_fin_s = EXP_MAX;
      man_fin_s = '1;
    end else begin
      ovf_s = 1'b0;
    end
    // s1_sign_r is always 0 for unsigned builds, so the cast drops nothing real.
    data_s = OUT_W'({s1_sign_r, exp_fin_s[EXP_W-1:0], man_fin_s});
  end

  // Stage 2 register: the output beat, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
      out_ovf     <= 1'b0;
    end else if (s2_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data    <= data_s;
        out_inexact <= inexact_s;
        out_ovf     <= ovf_s;
      end
    end
  end

  // Overflow counter: counts consumed saturated beats, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (consume_s && out_ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CNT_ONE;
    end
  end

  int2float_pipe_chk #(
    .OUT_W(OUT_W)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inexact(out_inexact),
    .out_ovf    (out_ovf)
  );

endmodule

// File: tb/tb_int2float_pipe.sv
// Bench for int2float_pipe: an unsigned and a signed instance share one
// stimulus stream; results are compared against an arithmetic reference.

module tb_int2float_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [10:0] in_data = 11'd0;
  logic        rnd_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        in_ready_u, out_valid_u, out_inexact_u, out_ovf_u;
  logic [6:0]  out_data_u;
  logic [7:0]  ovf_cnt_u;
  logic        in_ready_s, out_valid_s, out_inexact_s, out_ovf_s;
  logic [7:0]  out_data_s;
  logic [7:0]  ovf_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(0), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .rnd_mode(rnd_mode), .out_valid(out_valid_u),
    .out_ready(out_ready), .out_data(out_data_u), .out_inexact(out_inexact_u),
    .out_ovf(out_ovf_u), .ovf_cnt(ovf_cnt_u), .cnt_clr(cnt_clr)
  );

  int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .SIGNED(1), .CNT_W(8)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .rnd_mode(rnd_mode), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_inexact(out_inexact_s),
    .out_ovf(out_ovf_s), .ovf_cnt(ovf_cnt_s), .cnt_clr(cnt_clr)
  );

  // Reference: value = man * 2^e, picked by plain integer arithmetic.
  function automatic logic [7:0] ref_conv(input logic [10:0] d, input bit rnd,
                                          input bit sgn, output bit inx, output bit ovf);
    int m, e, man, r;
    bit s;
    s = sgn && d[10];
    m = s ? (2048 - int'(d)) : int'(d);
    e = 0;
    while ((m >> e) >= 16) e++;
    man = m >> e;
    r = m - (man << e);
    inx = (r != 0);
    ovf = 1'b0;
    if (rnd && e > 0 && ((2 * r > (1 << e)) || ((2 * r == (1 << e)) && (man % 2 == 1))))
      man++;
    if (man == 16) begin
      man = 8;
      e++;
    end
    if (e > 7) begin
      e = 7; man = 15; ovf = 1'b1; inx = 1'b1;
    end
    return {s, e[2:0], man[3:0]};
  endfunction

  task automatic step(input bit iv, input logic [10:0] d, input bit rm, input bit ordy);
    @(negedge clk);
    in_valid = iv; in_data = d; rnd_mode = rm; out_ready = ordy;
    #1;
  endtask

  // One word through an otherwise idle pipe; returns what sits on the outputs 2 cycles on.
  task automatic xfer(input logic [10:0] d, input bit rm, output logic [6:0] od,
                      output logic oi, output logic oo, output logic ov,
                      output logic [7:0] sd, output logic so);
    step(1'b1, d, rm, 1'b1);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    od = out_data_u; oi = out_inexact_u; oo = out_ovf_u; ov = out_valid_u;
    sd = out_data_s; so = out_ovf_s;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid_u); end
    n_tests++; if (out_data_u !== 7'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data_u); end
    n_tests++; if (out_inexact_u !== 1'b0 || out_ovf_u !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", out_inexact_u, out_ovf_u); end
    n_tests++; if (ovf_cnt_u !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", ovf_cnt_u); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 11'd0, 1'b0, 1'b1);
    n_tests++; if (in_ready_u !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_u); end
  endtask

  task automatic test_latency();
    logic [10:0] vals [3] = '{11'd0, 11'd13, 11'd24};
    logic [6:0]  expd [3] = '{7'h00, 7'h0D, 7'h1C};
    for (int t = 0; t < 6; t++) begin
      if (t < 3) step(1'b1, vals[t], 1'b0, 1'b1);
      else       step(1'b0, 11'd0, 1'b0, 1'b1);
      if (t < 2 || t == 5) begin
        n_tests++; if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL latency_idle[%0d]: out_valid got %b want 0", t, out_valid_u); end
      end else begin
        n_tests++;
        if (out_valid_u !== 1'b1 || out_data_u !== expd[t-2] || out_inexact_u !== 1'b0) begin
          n_fail++; $display("FAIL latency[%0d]: got v=%b d=%h i=%b want v=1 d=%h i=0", t, out_valid_u, out_data_u, out_inexact_u, expd[t-2]);
        end
      end
    end
  endtask

  task automatic test_rounding();
    logic [10:0] td [7] = '{11'd100, 11'd100, 11'd25, 11'd27, 11'd27, 11'd2047, 11'd2047};
    bit          tr [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [6:0]  tx [7] = '{7'h3C, 7'h3C, 7'h1C, 7'h1E, 7'h1D, 7'h7F, 7'h7F};
    bit          to [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [6:0] od; logic oi, oo, ov, so; logic [7:0] sd;
    for (int k = 0; k < 7; k++) begin
      xfer(td[k], tr[k], od, oi, oo, ov, sd, so);
      n_tests++;
      if (ov !== 1'b1 || od !== tx[k] || oi !== 1'b1 || oo !== to[k]) begin
        n_fail++; $display("FAIL round[%0d] in=%0d rnd=%0d: got v=%b d=%h i=%b o=%b want v=1 d=%h i=1 o=%b", k, td[k], tr[k], ov, od, oi, oo, tx[k], to[k]);
      end
    end
    n_tests++; if (ovf_cnt_u !== 8'd0) begin n_fail++; $display("FAIL ovf_cnt_before: got %0d want 0", ovf_cnt_u); end
    step(1'b0, 11'd0, 1'b0, 1'b1);
    n_tests++; if (ovf_cnt_u !== 8'd1) begin n_fail++; $display("FAIL ovf_cnt_after: got %0d want 1", ovf_cnt_u); end
  endtask

  task automatic test_signed();
    logic [10:0] td [3] = '{11'h400, 11'h7FF, 11'h000};
    logic [7:0]  tx [3] = '{8'hF8, 8'h81, 8'h00};
    logic [6:0] od; logic oi, oo, ov, so; logic [7:0] sd;
    for (int k = 0; k < 3; k++) begin
      xfer(td[k], 1'b0, od, oi, oo, ov, sd, so);
      n_tests++;
      if (out_valid_s !== 1'b1 || sd !== tx[k] || so !== 1'b0) begin
        n_fail++; $display("FAIL signed[%0d] in=%h: got v=%b d=%h o=%b want v=1 d=%h o=0", k, td[k], out_valid_s, sd, so, tx[k]);
      end
    end
  endtask

  task automatic test_reset_flight();
    step(1'b1, 11'd100, 1'b0, 1'b0);
    step(1'b1, 11'd27, 1'b0, 1'b0);
    step(1'b0, 11'd0, 1'b0, 1'b0);
    n_tests++; if (out_valid_u !== 1'b1) begin n_fail++; $display("FAIL flight_pre: out_valid got %b want 1", out_valid_u); end
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid_u !== 1'b0 || ovf_cnt_u !== 8'd0) begin n_fail++; $display("FAIL flight_async: got v=%b cnt=%0d want v=0 cnt=0", out_valid_u, ovf_cnt_u); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step(1'b0, 11'd0, 1'b0, 1'b1);
      n_tests++; if (out_valid_u !== 1'b0 || in_ready_u !== 1'b1) begin n_fail++; $display("FAIL flight_ghost[%0d]: got v=%b rdy=%b want v=0 rdy=1", t, out_valid_u, in_ready_u); end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] w [4];
    logic [6:0]  ex [4];
    bit ei, eo;
    int acc;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      w[k] = 11'($urandom);
      ex[k] = 7'(ref_conv(w[k], 1'b0, 1'b0, ei, eo));
    end
    for (int t = 0; t < 4; t++) begin
      step(1'b1, w[acc], 1'b0, 1'b0);
      if (in_ready_u) acc++;
      if (t >= 2) begin
        n_tests++; if (out_valid_u !== 1'b1 || out_data_u !== ex[0]) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want v=1 d=%h", t, out_valid_u, out_data_u, ex[0]); end
      end
    end
    n_tests++; if (acc !== 2 || in_ready_u !== 1'b0) begin n_fail++; $display("FAIL stall_accept: got acc=%0d rdy=%b want acc=2 rdy=0", acc, in_ready_u); end
    for (int k = 0; k < 4; k++) begin
      step(acc < 4, w[acc < 4 ? acc : 0], 1'b0, 1'b1);
      if (in_valid && in_ready_u) acc++;
      n_tests++; if (out_valid_u !== 1'b1 || out_data_u !== ex[k]) begin n_fail++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid_u, out_data_u, ex[k]); end
    end
    step(1'b0, 11'd0, 1'b0, 1'b1);
    n_tests++; if (acc !== 4 || out_valid_u !== 1'b0) begin n_fail++; $display("FAIL drain_end: got acc=%0d v=%b want acc=4 v=0", acc, out_valid_u); end
  endtask

  task automatic test_ovf_counter();
    logic [6:0] od; logic oi, oo, ov, so; logic [7:0] sd;
    for (int k = 0; k < 260; k++) step(1'b1, 11'd2047, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 11'd0, 1'b0, 1'b1);
    n_tests++; if (ovf_cnt_u !== 8'd255) begin n_fail++; $display("FAIL ovf_sat: got %0d want 255", ovf_cnt_u); end
    cnt_clr = 1'b1;
    step(1'b0, 11'd0, 1'b0, 1'b1);
    cnt_clr = 1'b0;
    n_tests++; if (ovf_cnt_u !== 8'd0) begin n_fail++; $display("FAIL ovf_clr: got %0d want 0", ovf_cnt_u); end
    xfer(11'd2047, 1'b1, od, oi, oo, ov, sd, so);
    step(1'b0, 11'd0, 1'b0, 1'b1);
    n_tests++; if (ovf_cnt_u !== 8'd1) begin n_fail++; $display("FAIL ovf_inc: got %0d want 1", ovf_cnt_u); end
    xfer(11'd2047, 1'b1, od, oi, oo, ov, sd, so);
    cnt_clr = 1'b1;
    step(1'b0, 11'd0, 1'b0, 1'b1);
    cnt_clr = 1'b0;
    n_tests++; if (ovf_cnt_u !== 8'd0) begin n_fail++; $display("FAIL ovf_clr_wins: got %0d want 0", ovf_cnt_u); end
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       i;
    logic       o;
  } exp_t;

  task automatic test_random();
    exp_t q_u [$];
    exp_t q_s [$];
    exp_t e;
    bit iv, rm, ordy, ei, eo;
    logic [10:0] d;
    int ref_cnt;
    bit stall_u;
    logic [8:0] prev_u;
    ref_cnt = 0; stall_u = 1'b0; prev_u = '0;
    for (int t = 0; t < 610; t++) begin
      iv   = (t < 600) && ($urandom_range(0, 3) != 0);
      rm   = $urandom_range(0, 1) != 0;
      ordy = (t >= 600) || ($urandom_range(0, 3) != 0);
      d    = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 40)) : 11'($urandom);
      step(iv, d, rm, ordy);
      if (stall_u) begin
        n_tests++; if ({out_valid_u, out_data_u, out_inexact_u} !== prev_u) begin n_fail++; $display("FAIL rand_hold[%0d]: got %h want %h", t, {out_valid_u, out_data_u, out_inexact_u}, prev_u); end
      end
      if (out_valid_u && out_ready) begin
        n_tests++;
        if (q_u.size() == 0) begin
          n_fail++; $display("FAIL rand_u_spurious[%0d]: got d=%h want no output", t, out_data_u);
        end else begin
          e = q_u.pop_front();
          if ({out_data_u, out_inexact_u, out_ovf_u} !== {e.d[6:0], e.i, e.o}) begin
            n_fail++; $display("FAIL rand_u[%0d]: got d=%h i=%b o=%b want d=%h i=%b o=%b", t, out_data_u, out_inexact_u, out_ovf_u, e.d[6:0], e.i, e.o);
          end
          if (e.o && ref_cnt < 255) ref_cnt++;
        end
      end
      if (out_valid_s && out_ready) begin
        n_tests++;
        if (q_s.size() == 0) begin
          n_fail++; $display("FAIL rand_s_spurious[%0d]: got d=%h want no output", t, out_data_s);
        end else begin
          e = q_s.pop_front();
          if ({out_data_s, out_inexact_s, out_ovf_s} !== {e.d, e.i, e.o}) begin
            n_fail++; $display("FAIL rand_s[%0d]: got d=%h i=%b o=%b want d=%h i=%b o=%b", t, out_data_s, out_inexact_s, out_ovf_s, e.d, e.i, e.o);
          end
        end
      end
      if (in_valid && in_ready_u) begin
        e.d = ref_conv(d, rm, 1'b0, ei, eo); e.i = ei; e.o = eo;
        q_u.push_back(e);
      end
      if (in_valid && in_ready_s) begin
        e.d = ref_conv(d, rm, 1'b1, ei, eo); e.i = ei; e.o = eo;
        q_s.push_back(e);
      end
      stall_u = out_valid_u && !out_ready;
      prev_u  = {out_valid_u, out_data_u, out_inexact_u};
    end
    n_tests++; if (q_u.size() != 0 || q_s.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d/%0d pending want 0/0", q_u.size(), q_s.size()); end
    n_tests++; if (ovf_cnt_u !== 8'(ref_cnt)) begin n_fail++; $display("FAIL rand_ovf_cnt: got %0d want %0d", ovf_cnt_u, ref_cnt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_signed();
    test_reset_flight();
    test_back_to_back();
    test_ovf_counter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
